// File: rtl/subset_scan_ctrl.sv
// Scan controller that streams all 256 grid positions to a shared subset evaluator and counts activated ones.
// Optional build macro SUBSET_SCAN_BITMAP_EN adds a per-position activation map read through map_addr/map_bit.
module subset_scan_ctrl #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] central,
  input  logic [23:0] radius_square,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [8:0]  candidate,
  output logic        err,
  output logic        sub_en,
  output logic [7:0]  sub_position,
  output logic [23:0] sub_central,
  output logic [23:0] sub_radius_square,
  output logic [1:0]  sub_mode,
  input  logic        sub_valid,
  input  logic        sub_activated,
`ifdef SUBSET_SCAN_BITMAP_EN
  input  logic [7:0]  map_addr,
  output logic        map_bit,
`endif
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  pos;
  logic [3:0]  outstanding;
  logic [8:0]  resp_cnt;
  logic        issue;
  logic        resp_ok;
  logic        at_limit;

  // Handshake: every cycle with sub_en=1 is one accepted request (the evaluator
  // never stalls); each sub_valid=1 cycle returns exactly one response, in issue order.
  assign at_limit = (outstanding == 4'(MAX_OUT));
  assign resp_ok  = sub_valid && (outstanding != 4'd0);
  assign issue    = (state == ISSUE) && (!at_limit || sub_valid);

  assign sub_en       = issue;
  assign sub_position = pos;
  assign busy         = (state == ISSUE) || (state == DRAIN);
  assign done         = (state == DONE);
  assign fsm_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      pos               <= 8'd0;
      outstanding       <= 4'd0;
      resp_cnt          <= 9'd0;
      candidate         <= 9'd0;
      err               <= 1'b0;
      sub_central       <= 24'd0;
      sub_radius_square <= 24'd0;
      sub_mode          <= 2'd0;
    end else begin
      // A response with nothing in flight is a protocol violation: flag it, drop it.
      if (sub_valid && (outstanding == 4'd0))
        err <= 1'b1;

      case ({issue, resp_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (resp_ok) begin
        resp_cnt <= resp_cnt + 9'd1;
        if (sub_activated && (candidate != 9'd256))
          candidate <= candidate + 9'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            sub_central       <= central;
            sub_radius_square <= radius_square;
            sub_mode          <= mode;
            candidate         <= 9'd0;
            resp_cnt          <= 9'd0;
            pos               <= 8'd0;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (pos == 8'hFF)
              state <= DRAIN;
            else
              pos <= pos + 8'd1;
          end
        end
        DRAIN: begin
          if ((outstanding == 4'd0) && (resp_cnt == 9'd256))
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUBSET_SCAN_BITMAP_EN
  logic [255:0] map;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map <= '0;
    end else if ((state == IDLE) && start) begin
      map <= '0;
    end else if (resp_ok && !resp_cnt[8]) begin
      map[resp_cnt[7:0]] <= sub_activated;
    end
  end

  assign map_bit = map[map_addr];
`endif

endmodule

// File: tb/tb_subset_scan_ctrl.sv
// Bench for subset_scan_ctrl: a latency-programmable evaluator model answers requests from a
// per-position activation table; expected job results are queued at start and checked on done.
module tb_subset_scan_ctrl;

  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] central;
  logic [23:0] radius_square;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [8:0]  candidate;
  logic        err;
  logic        sub_en;
  logic [7:0]  sub_position;
  logic [23:0] sub_central;
  logic [23:0] sub_radius_square;
  logic [1:0]  sub_mode;
  logic        sub_valid;
  logic        sub_activated;
  logic [1:0]  fsm_state;
`ifdef SUBSET_SCAN_BITMAP_EN
  logic [7:0]  map_addr;
  logic        map_bit;
`endif

  subset_scan_ctrl #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .central(central),
    .radius_square(radius_square),
    .mode(mode),
    .busy(busy),
    .done(done),
    .candidate(candidate),
    .err(err),
    .sub_en(sub_en),
    .sub_position(sub_position),
    .sub_central(sub_central),
    .sub_radius_square(sub_radius_square),
    .sub_mode(sub_mode),
    .sub_valid(sub_valid),
    .sub_activated(sub_activated),
`ifdef SUBSET_SCAN_BITMAP_EN
    .map_addr(map_addr),
    .map_bit(map_bit),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // evaluator model state and scoreboard
  logic        act_map [256];
  int          lat;
  int          pend_due[$];
  logic        pend_act[$];
  logic [58:0] exp_q[$];       // {central, radius_square, mode, candidate}
  logic        spur_req;
  int          exp_pos;
  int          first_iss;
  int          last_iss;
  int          issued_total;
  int          done_cnt;
  logic        chk_consec;
  logic [8:0]  last_cand;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int count_act();
    int n = 0;
    for (int i = 0; i < 256; i++) n += int'(act_map[i]);
    return n;
  endfunction

  // pattern: 0 all ones, 1 random, 2 only 0x00/0x7F/0xFF
  task automatic set_pattern(input int pattern);
    for (int i = 0; i < 256; i++) begin
      case (pattern)
        0:       act_map[i] = 1'b1;
        1:       act_map[i] = 1'($urandom_range(0, 1));
        default: act_map[i] = (i == 8'h00) || (i == 8'h7F) || (i == 8'hFF);
      endcase
    end
  endtask

  task automatic pulse_start(input logic [23:0] c, input logic [23:0] r, input logic [1:0] m);
    @(negedge clk);
    central = c; radius_square = r; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input int lat_in, input int pattern, input logic poke);
    logic [23:0] c;
    logic [23:0] r;
    logic [1:0]  m;
    int          base;
    int          budget;
    lat = lat_in;
    set_pattern(pattern);
    chk_consec = (lat_in == 1);
    c = 24'($urandom); r = 24'($urandom); m = 2'($urandom_range(0, 3));
    exp_q.push_back({c, r, m, 9'(count_act())});
    last_cand = 9'(count_act());
    base = done_cnt;
    pulse_start(c, r, m);
    if (poke) begin
      repeat (20) @(negedge clk);
      central = ~c; radius_square = ~r; mode = ~m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    budget = 3000;
    while ((done_cnt == base) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    check("done_timeout", 32'(done_cnt - base), 32'd1);
    repeat (4) @(negedge clk);
    check("idle_after_job", {31'd0, busy}, 32'd0);
    check("single_done", 32'(done_cnt - base), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; central = '0; radius_square = '0; mode = '0;
    sub_valid = 1'b0; sub_activated = 1'b0; spur_req = 1'b0;
    lat = 1; exp_pos = 0; first_iss = -1; last_iss = -1; issued_total = 0;
    done_cnt = 0; chk_consec = 1'b0; last_cand = '0; n_checks = 0; n_fail = 0;
`ifdef SUBSET_SCAN_BITMAP_EN
    map_addr = '0;
`endif
    for (int i = 0; i < 256; i++) act_map[i] = 1'b0;

    fork
      // evaluator driver + output monitor
      forever begin
        @(negedge clk);
        if (rst) begin
          pend_due.delete(); pend_act.delete();
          sub_valid = 1'b0; sub_activated = 1'b0;
        end else if (spur_req) begin
          sub_valid = 1'b1; sub_activated = 1'b1; spur_req = 1'b0;
        end else if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
          sub_valid = 1'b1;
          sub_activated = pend_act.pop_front();
          void'(pend_due.pop_front());
        end else begin
          sub_valid = 1'b0;
          sub_activated = 1'($urandom_range(0, 1));
        end
        #1;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            logic [58:0] e;
            e = exp_q.pop_front();
            check("candidate", {23'd0, candidate}, {23'd0, e[8:0]});
            check("err_at_done", {31'd0, err}, 32'd0);
            check("sub_central", {8'd0, sub_central}, {8'd0, e[58:35]});
            check("sub_radius_square", {8'd0, sub_radius_square}, {8'd0, e[34:11]});
            check("sub_mode", {30'd0, sub_mode}, {30'd0, e[10:9]});
            check("issued_count", 32'(exp_pos), 32'd256);
            if (chk_consec) check("consecutive_issue", 32'(last_iss - first_iss), 32'd255);
          end
        end else if (!busy) begin
          exp_pos = 0;
          first_iss = -1;
        end
        if (sub_en) begin
          if (exp_pos > 255) check("extra_issue", 32'd1, 32'd0);
          else check("position", {24'd0, sub_position}, 32'(exp_pos));
          pend_due.push_back(cyc + lat);
          pend_act.push_back(act_map[sub_position]);
          if (pend_due.size() > MAX_OUT) check("outstanding_limit", 32'(pend_due.size()), 32'(MAX_OUT));
          if (first_iss < 0) first_iss = cyc;
          last_iss = cyc;
          exp_pos++;
          issued_total++;
        end
      end
    join_none

    // reset state
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sub_en", {31'd0, sub_en}, 32'd0);
    check("rst_candidate", {23'd0, candidate}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_sub_central", {8'd0, sub_central}, 32'd0);
    check("rst_state_idle", {30'd0, fsm_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // zero-latency evaluator, all activated
    run_job(1, 0, 1'b0);
    // fixed 3-cycle latency with a random pattern
    run_job(3, 1, 1'b0);
    // sparse pattern at the scan boundaries
    run_job(2, 2, 1'b0);
`ifdef SUBSET_SCAN_BITMAP_EN
    for (int a = 0; a < 256; a++) begin
      map_addr = 8'(a);
      #1;
      if (map_bit !== act_map[a]) check("map_bit", {31'd0, map_bit}, {31'd0, act_map[a]});
      else check("map_bit", {31'd0, map_bit}, {31'd0, act_map[a]});
    end
`endif

    // abort after 100 issued requests
    begin
      int base_iss;
      int base_done;
      int budget;
      lat = 1;
      set_pattern(1);
      base_iss = issued_total;
      base_done = done_cnt;
      pulse_start(24'h123456, 24'h abcdef, 2'd1);
      budget = 1000;
      while (((issued_total - base_iss) < 100) && (budget > 0)) begin
        @(posedge clk);
        #2;
        budget--;
      end
      check("abort_reached_100", {31'd0, ((issued_total - base_iss) >= 100)}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_sub_en", {31'd0, sub_en}, 32'd0);
      check("abort_candidate", {23'd0, candidate}, 32'd0);
      check("abort_err", {31'd0, err}, 32'd0);
      check("abort_sub_central", {8'd0, sub_central}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    end

    // rescan from 0x00 with a start pulsed while busy
    run_job(3, 1, 1'b1);

    // spurious response in IDLE
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    check("spurious_err", {31'd0, err}, 32'd1);
    check("spurious_candidate", {23'd0, candidate}, {23'd0, last_cand});
    check("spurious_idle", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subset_scan_ctrl.md
SUBSET_SCAN_CTRL -- requirements
Module: subset_scan_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding evaluator requests (legal range 1-8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-005 SHALL have port central  input  24  three centres {xA,yA,xB,yB,xC,yC}, 4 bits each.
REQ-006 SHALL have port radius_square  input  24  three squared radii, 8 bits each.
REQ-007 SHALL have port mode  input  2  set-combination selector, forwarded to the evaluator.
REQ-008 SHALL have port busy  output  1  high from job acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the job completes.
REQ-010 SHALL have port candidate  output  9  count of activated positions, 0-256.
REQ-011 SHALL have port err  output  1  sticky protocol-error flag.
REQ-012 SHALL have ports sub_en (output, 1), sub_position (output, 8, {x[7:4],y[3:0]}), sub_central (output, 24), sub_radius_square (output, 24) and sub_mode (output, 2), forming the request side to one shared subset evaluator.
REQ-013 SHALL have ports sub_valid (input, 1) and sub_activated (input, 1), forming the in-order response side from the evaluator.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-015 In IDLE with start=1, SHALL latch central, radius_square and mode into sub_central, sub_radius_square and sub_mode, clear candidate and the position counter, and go to ISSUE on the next edge.
REQ-016 SHALL hold the sub_* job fields stable from latch until the next accepted start.
REQ-017 In ISSUE, SHALL assert sub_en with sub_position = pos when outstanding < MAX_OUT, or when outstanding = MAX_OUT and sub_valid=1 in the same cycle.
REQ-018 SHALL increment pos by 1 per issued request, in order 0x00 to 0xFF (y fastest).
REQ-019 SHALL go to DRAIN after issuing pos=0xFF; pos SHALL NOT wrap and no 257th request SHALL be issued.
REQ-020 SHALL track outstanding as +1 per issue and -1 per sub_valid; simultaneous issue and response leave it unchanged.
REQ-021 SHALL increment candidate on each sub_valid with sub_activated=1; candidate saturates at 256.
REQ-022 SHALL go from DRAIN to DONE when outstanding = 0 and 256 responses have been received.
REQ-023 In DONE, SHALL pulse done for exactly one cycle, return to IDLE on the next edge, and hold candidate until the next accepted start.
REQ-024 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 sub_valid with outstanding = 0 SHALL set err, leave candidate unchanged, and be otherwise ignored; err clears only on reset.
REQ-027 sub_activated SHALL be ignored when sub_valid = 0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, and clear busy, done, sub_en, candidate, err, pos and outstanding to 0, and the sub_* job fields to 0.
REQ-029 Reset asserted mid-job SHALL abort the job, with no done pulse; responses arriving after reset release SHALL set err.

Configuration
REQ-030 With SUBSET_SCAN_BITMAP_EN defined, SHALL add ports map_addr (input, 8) and map_bit (output, 1), and SHALL store sub_activated of response n in bit n of a 256-bit map, cleared at job acceptance.
REQ-031 map_bit SHALL combinationally return map[map_addr].
REQ-032 Without SUBSET_SCAN_BITMAP_EN, SHALL omit the map_addr and map_bit ports and the map storage; all other behaviour is identical.

Verification
REQ-033 Zero-latency evaluator, all sub_activated=1 -> 256 consecutive sub_en cycles, done pulse, candidate=256, err=0.
REQ-034 Evaluator with 3-cycle fixed latency, MAX_OUT=2 -> outstanding never exceeds 2, positions issued 0x00 to 0xFF in order, candidate equals the reference-model count.
REQ-035 Activated only at positions 0x00, 0x7F and 0xFF -> candidate=3; with SUBSET_SCAN_BITMAP_EN, map_bit=1 at exactly those addresses.
REQ-036 start pulsed during busy, then a spurious sub_valid in IDLE -> second start ignored, err=1 after the spurious response.
REQ-037 rst asserted after 100 issued requests -> outputs 0 in the same cycle, no done pulse; a new start rescans from 0x00.
